// File: rtl/rgb_fade_pwm_if.sv
// Bundle of control, target, level and status signals between the Wishbone
// register block (master) and the fade/PWM engine (slave).
//   enable, load, target_r/g/b, fade_div : master -> slave
//   pwm_o, level_r/g/b, busy, done       : slave -> master
interface rgb_fade_pwm_if #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned PWM_W = 8
);
    logic             enable;
    logic             load;
    logic [PWM_W-1:0] target_r;
    logic [PWM_W-1:0] target_g;
    logic [PWM_W-1:0] target_b;
    logic [DIV_W-1:0] fade_div;
    logic [2:0]       pwm_o;
    logic [PWM_W-1:0] level_r;
    logic [PWM_W-1:0] level_g;
    logic [PWM_W-1:0] level_b;
    logic             busy;
    logic             done;

    modport master (
        output enable, load, target_r, target_g, target_b, fade_div,
        input  pwm_o, level_r, level_g, level_b, busy, done
    );

    modport slave (
        input  enable, load, target_r, target_g, target_b, fade_div,
        output pwm_o, level_r, level_g, level_b, busy, done
    );
endinterface

// File: rtl/rgb_fade_pwm.sv
// Per-channel brightness fade engine and PWM generator feeding the RGB LED
// driver. Levels step by one toward latched targets on every prescaler tick;
// each level drives a PWM compare against a free-running 0..2^PWM_W-2 counter.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : rgb_fade_pwm_if.slave (enable, load, targets, fade_div in;
//          pwm_o, levels, busy, done out -- all outputs registered)
module rgb_fade_pwm #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned PWM_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    rgb_fade_pwm_if.slave  bus
);

    localparam int unsigned NCH = 3;
    // Last counter value before wrap: 2^PWM_W-2, so level 2^PWM_W-1 is always on.
    localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [NCH-1:0][PWM_W-1:0] level_q, level_d;
    logic [NCH-1:0][PWM_W-1:0] target_q, target_d;
    logic [NCH-1:0][PWM_W-1:0] target_in;
    logic [DIV_W-1:0]          presc_q, presc_d;
    logic [PWM_W-1:0]          cnt_q, cnt_d;
    logic [NCH-1:0]            pwm_q, pwm_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      tick;

    assign target_in = {bus.target_b, bus.target_g, bus.target_r};

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= '0;
            target_q <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            pwm_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            level_q  <= level_d;
            target_q <= target_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state: prescaler, fade steps, status and PWM compare
    always_comb begin
        level_d  = level_q;
        target_d = target_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        pwm_d    = '0;
        tick     = 1'b0;

        // A load always wins over a coincident tick: it restarts the step period.
        if (bus.load) begin
            target_d = target_in;
            presc_d  = '0;
        end else if (bus.enable) begin
            if (presc_q >= bus.fade_div) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end

        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (tick) begin
                if (level_q[ch] < target_q[ch]) begin
                    level_d[ch] = level_q[ch] + PWM_W'(1);
                end else if (level_q[ch] > target_q[ch]) begin
                    level_d[ch] = level_q[ch] - PWM_W'(1);
                end
            end
        end

        // Status looks at the current registers, so it trails the levels by a cycle.
        busy_d = (level_q != target_q);
        done_d = busy_q & ~busy_d;

        if (bus.enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + PWM_W'(1);
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                pwm_d[ch] = (cnt_q < level_q[ch]);
            end
        end
    end

    assign bus.pwm_o   = pwm_q;
    assign bus.level_r = level_q[0];
    assign bus.level_g = level_q[1];
    assign bus.level_b = level_q[2];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
